// File: rtl/pueo_trig_pkg.sv
// Shared types and sizes for the PUEO trigger metadata capture block.
// Record layout: event number, timestamp, then one metadata word per TURFIO.
package pueo_trig_pkg;

    localparam int NUM_TIO = 4;
    localparam int META_W  = 64;
    localparam int EVT_W   = 32;
    localparam int TS_W    = 32;
    localparam int BEATS   = 5;

    typedef struct packed {
        logic [EVT_W-1:0]                evt;
        logic [TS_W-1:0]                 timestamp;
        logic [NUM_TIO-1:0][META_W-1:0]  meta;
    } trig_record_t;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_HDR,
        SER_M0,
        SER_M1,
        SER_M2,
        SER_M3
    } ser_state_t;

    // Header beat: event number in the upper half, timestamp in the lower half.
    function automatic logic [META_W-1:0] hdr_beat(input trig_record_t rec);
        return {rec.evt, rec.timestamp};
    endfunction

endpackage

// File: rtl/pueo_trig_meta_ram.sv
// Simple dual-port record store: synchronous write, registered read, no reset on contents.
// A read of the address being written in the same clock returns the old contents.
module pueo_trig_meta_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pueo_trig_meta_capture.sv
// Captures one metadata record per master trigger into a FIFO and streams each as 5 x 64-bit beats.
// Optional busy/holdoff output is enabled by defining PUEO_TRIG_META_BUSY_EN.
module pueo_trig_meta_capture
    import pueo_trig_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int BUSY_MARGIN = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ce_i,
    input  logic               trig_i,
    input  logic [META_W-1:0]  tio0_meta_i,
    input  logic [META_W-1:0]  tio1_meta_i,
    input  logic [META_W-1:0]  tio2_meta_i,
    input  logic [META_W-1:0]  tio3_meta_i,
    output logic [META_W-1:0]  m_tdata_o,
    output logic               m_tvalid_o,
    output logic               m_tlast_o,
    input  logic               m_tready_i,
    output logic               busy_o,
    output logic [15:0]        drop_count_o,
    output logic [EVT_W-1:0]   event_count_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int REC_W  = $bits(trig_record_t);

`ifdef PUEO_TRIG_META_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [TS_W-1:0]                timestamp;
    logic [EVT_W-1:0]               event_count;
    logic [15:0]                    drop_count;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [PTR_W-1:0]               occupancy;
    logic [PTR_W-1:0]               free_slots;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           push;
    logic                           pop;
    logic                           drop;
    logic                           busy_q;
    ser_state_t                     state;
    trig_record_t                   wr_rec;
    trig_record_t                   rd_rec;
    logic [NUM_TIO-1:0][META_W-1:0] hold_meta;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign occupancy  = wr_ptr - rd_ptr;
    assign free_slots = PTR_W'(DEPTH) - occupancy;

    // A header accept frees a slot in the same clock, so a full FIFO still takes the push.
    assign pop  = (state == SER_HDR) && m_tready_i;
    assign push = trig_i && (!fifo_full || pop);
    assign drop = trig_i && fifo_full && !pop;

    always_comb begin
        wr_rec           = '0;
        wr_rec.evt       = event_count;
        wr_rec.timestamp = timestamp;
        wr_rec.meta[0]   = tio0_meta_i;
        wr_rec.meta[1]   = tio1_meta_i;
        wr_rec.meta[2]   = tio2_meta_i;
        wr_rec.meta[3]   = tio3_meta_i;
    end

    pueo_trig_meta_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (REC_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_rec),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_rec)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timestamp   <= '0;
            event_count <= '0;
            drop_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (ce_i) begin
                timestamp <= timestamp + TS_W'(1);
            end
            // Drops still consume an event number so gaps reveal losses downstream.
            if (trig_i) begin
                event_count <= event_count + EVT_W'(1);
            end
            if (drop) begin
                drop_count <= sat_inc(drop_count);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= BUSY_EN && (free_slots <= PTR_W'(BUSY_MARGIN));
        end
    end

    assign busy_o = busy_q;

    // Metadata beats come from a private copy, so the popped slot can be refilled at once.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            hold_meta <= rd_rec.meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= SER_IDLE;
        end else begin
            case (state)
                SER_IDLE: if (!fifo_empty) state <= SER_HDR;
                SER_HDR:  if (m_tready_i)  state <= SER_M0;
                SER_M0:   if (m_tready_i)  state <= SER_M1;
                SER_M1:   if (m_tready_i)  state <= SER_M2;
                SER_M2:   if (m_tready_i)  state <= SER_M3;
                SER_M3:   if (m_tready_i)  state <= fifo_empty ? SER_IDLE : SER_HDR;
                default:                   state <= SER_IDLE;
            endcase
        end
    end

    // Header data is the RAM read port itself; its slot cannot be rewritten until the pop.
    always_comb begin
        m_tdata_o = '0;
        case (state)
            SER_HDR: m_tdata_o = hdr_beat(rd_rec);
            SER_M0:  m_tdata_o = hold_meta[0];
            SER_M1:  m_tdata_o = hold_meta[1];
            SER_M2:  m_tdata_o = hold_meta[2];
            SER_M3:  m_tdata_o = hold_meta[3];
            default: m_tdata_o = '0;
        endcase
    end

    assign m_tvalid_o    = (state != SER_IDLE);
    assign m_tlast_o     = (state == SER_M3);
    assign drop_count_o  = drop_count;
    assign event_count_o = event_count;

endmodule
